// File: rtl/alu_pkg.sv
// Shared ALU / multiply-divide sequencer definitions: ALU opcodes,
// sequencer op encodings, sequencer state enum and the default ALU width.
package alu_pkg;

  localparam int ALU_W = 16;

  // Opcodes understood by the shared combinational ALU
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd6;

  // Sequencer op encodings: bit0 selects divide, bit1 selects signed
  localparam logic [1:0] SEQ_MULU = 2'd0;
  localparam logic [1:0] SEQ_DIVU = 2'd1;
  localparam logic [1:0] SEQ_MULS = 2'd2;
  localparam logic [1:0] SEQ_DIVS = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_RUN  = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } seq_state_e;

  // Divide ops share bit0 with SEQ_DIVU / SEQ_DIVS
  function automatic logic seq_is_div(input logic [1:0] op);
    return op[0] == SEQ_DIVU[0];
  endfunction

endpackage

// File: rtl/alu_seq_negate.sv
// Conditional two's-complement negator used by the sequencer to form
// operand magnitudes before the loop and to restore signs after it.
module alu_seq_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  // Negate when requested, otherwise pass through
  always_comb o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 16x16 multiply / 16/16 divide sequencer that borrows the
// shared ALU adder while busy. Shift-add multiply, restoring divide.
// Build option: define ALU_SEQ_SIGNED_EN to make ops 2/3 signed; when it is
// undefined ops 2/3 alias ops 0/1 and PRE/POST are plain pass-through cycles.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic [WIDTH-1:0] opnd_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div0,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r
);

  seq_state_e       r_state, w_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div0;

  logic             w_is_div, w_div0_hit;
  logic [WIDTH-1:0] w_rsh;
  logic             w_ge, w_carry;
  logic [WIDTH-1:0] w_pre_a, w_pre_b, w_post_hi, w_post_lo;

  assign w_is_div   = seq_is_div(r_op);
  assign w_div0_hit = w_is_div && (r_b == '0);

  // Divide step: shift the next dividend bit into the partial remainder;
  // the 17th bit (old hi msb) forces a subtract since it exceeds any divisor.
  assign w_rsh   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_ge    = r_hi[WIDTH-1] | ~(w_rsh < r_b);
  // Multiply step: the ALU adder has no carry out, recover it by wrap check
  assign w_carry = (alu_r < r_hi);

`ifdef ALU_SEQ_SIGNED_EN
  logic                   w_signed;
  logic                   r_neg_q, r_neg_r;
  logic [WIDTH-1:0]       w_nin_a, w_nin_b, w_nout_a, w_nout_b;
  logic                   w_nen_a, w_nen_b;
  logic [2*WIDTH-1:0]     w_prod;

  assign w_signed = r_op[1];

  // Narrow negators take |a|,|b| in PRE and fix remainder/quotient in POST
  always_comb begin
    w_nin_a = r_hi;
    w_nin_b = r_lo;
    w_nen_a = r_neg_r;
    w_nen_b = r_neg_q;
    if (r_state == S_PRE) begin
      w_nin_a = r_a;
      w_nin_b = r_b;
      w_nen_a = w_signed & r_a[WIDTH-1];
      w_nen_b = w_signed & r_b[WIDTH-1];
    end
  end

  alu_seq_negate #(.W(WIDTH)) u_neg_a (.i_val(w_nin_a), .i_neg(w_nen_a), .o_val(w_nout_a));
  alu_seq_negate #(.W(WIDTH)) u_neg_b (.i_val(w_nin_b), .i_neg(w_nen_b), .o_val(w_nout_b));
  alu_seq_negate #(.W(2*WIDTH)) u_neg_p (.i_val({r_hi, r_lo}), .i_neg(r_neg_q), .o_val(w_prod));

  assign w_pre_a   = w_nout_a;
  assign w_pre_b   = w_nout_b;
  assign w_post_hi = w_is_div ? w_nout_a : w_prod[2*WIDTH-1:WIDTH];
  assign w_post_lo = w_is_div ? w_nout_b : w_prod[WIDTH-1:0];

  // Result signs recorded in PRE: quotient/product sign and remainder sign
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == S_PRE) begin
      r_neg_q <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
      r_neg_r <= w_signed & w_is_div & r_a[WIDTH-1];
    end
  end
`else
  logic w_unused_op1;
  assign w_unused_op1 = r_op[1];
  assign w_pre_a   = r_a;
  assign w_pre_b   = r_b;
  assign w_post_hi = r_hi;
  assign w_post_lo = r_lo;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state, handshake and ALU borrow outputs
  always_comb begin
    w_next  = r_state;
    done    = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = 3'd0;
    busy    = (r_state == S_PRE) || (r_state == S_RUN) || (r_state == S_POST);
    alu_own = busy;
    case (r_state)
      S_IDLE: if (start) w_next = S_PRE;
      S_PRE:  w_next = w_div0_hit ? S_DONE : S_RUN;
      S_RUN: begin
        alu_a  = w_is_div ? w_rsh : r_hi;
        alu_b  = w_is_div ? r_b : r_a;
        alu_op = w_is_div ? ALU_SUB : ALU_ADD;
        if (r_cnt == CNT_W'(1)) w_next = S_POST;
      end
      S_POST: w_next = S_DONE;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op   <= 2'd0;
      r_a    <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
      r_div0 <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_op   <= op;
          r_a    <= opnd_a;
          r_b    <= opnd_b;
          r_div0 <= 1'b0;
        end
        S_PRE: if (w_div0_hit) begin
          r_hi   <= r_a;
          r_lo   <= '1;
          r_div0 <= 1'b1;
        end else begin
          // r_a = multiplicand magnitude, r_b = divisor magnitude
          r_a   <= w_pre_a;
          r_b   <= w_pre_b;
          r_hi  <= '0;
          r_lo  <= w_is_div ? w_pre_a : w_pre_b;
          r_cnt <= CNT_W'(WIDTH);
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_is_div) begin
            r_hi <= w_ge ? alu_r : w_rsh;
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
          end else if (r_lo[0]) begin
            r_hi <= {w_carry, alu_r[WIDTH-1:1]};
            r_lo <= {alu_r[0], r_lo[WIDTH-1:1]};
          end else begin
            r_hi <= {1'b0, r_hi[WIDTH-1:1]};
            r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
          end
        end
        S_POST: begin
          r_hi <= w_post_hi;
          r_lo <= w_post_lo;
        end
        default: ;
      endcase
    end
  end

  assign res_hi = r_hi;
  assign res_lo = r_lo;
  assign div0   = r_div0;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed cases, handshake, reset
// abort and randomized ops against an arithmetic reference model.
module tb_alu_muldiv_seq;

  logic        clk, rst_n, start;
  logic [1:0]  op;
  logic [15:0] opnd_a, opnd_b;
  logic        busy, done, div0, alu_own;
  logic [15:0] res_hi, res_lo, alu_a, alu_b, alu_r;
  logic [2:0]  alu_op;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 0;

  alu_muldiv_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .opnd_a(opnd_a), .opnd_b(opnd_b), .busy(busy), .done(done),
    .res_hi(res_hi), .res_lo(res_lo), .div0(div0), .alu_own(alu_own),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r)
  );

  // Shared ALU stand-in
  assign alu_r = (alu_op == 3'd2) ? alu_a + alu_b :
                 (alu_op == 3'd6) ? alu_a - alu_b : 16'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {div0, hi, lo} from plain arithmetic
  function automatic logic [32:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic sg;
    int sa, sb, q, r;
    logic [31:0] p;
`ifdef ALU_SEQ_SIGNED_EN
    sg = o[1];
`else
    sg = 1'b0;
`endif
    if (o[0]) begin
      if (b == 16'h0) return {1'b1, a, 16'hFFFF};
      if (sg) begin sa = $signed(a); sb = $signed(b); end
      else    begin sa = int'(a);    sb = int'(b);    end
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[15:0], q[15:0]};
    end
    if (sg) begin
      sa = $signed(a); sb = $signed(b);
      q = sa * sb;
      p = q;
    end else begin
      p = 32'(a) * 32'(b);
    end
    return {1'b0, p};
  endfunction

  // alu_own must mirror busy every cycle
  always @(negedge clk) if (mon_en) chk("own", {31'b0, alu_own}, {31'b0, busy});

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [32:0] e;
    int n, nalu, lat;
    e = model(o, a, b);
    lat = (o[0] && b == 16'h0) ? 2 : 19;
    @(negedge clk);
    start = 1'b1; op = o; opnd_a = a; opnd_b = b;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "/busy1"}, {31'b0, busy}, 32'd1);
    n = 1; nalu = 0;
    while (n < 40) begin
      if (alu_op != 3'd0) nalu++;
      if (done) break;
      @(negedge clk);
      n++;
    end
    chk({tag, "/lat"}, n, lat);
    chk({tag, "/busy_at_done"}, {31'b0, busy}, 32'd0);
    chk({tag, "/alu_cycles"}, nalu, (lat == 2) ? 0 : 16);
    chk({tag, "/res"}, {res_hi, res_lo}, e[31:0]);
    chk({tag, "/div0"}, {31'b0, div0}, {31'b0, e[32]});
  endtask

  initial begin
    int n;
    logic [32:0] e;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; opnd_a = 16'h0; opnd_b = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst/busy", {31'b0, busy}, 32'd0);
    chk("rst/done", {31'b0, done}, 32'd0);
    chk("rst/res", {res_hi, res_lo}, 32'd0);
    chk("rst/alu", {13'b0, alu_op, alu_a}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1;

    // Directed
    run_op("mulu1", 2'd0, 16'h1234, 16'h5678);
    chk("mulu1/const", {res_hi, res_lo}, 32'h0626_0060);
    run_op("mulu_max", 2'd0, 16'hFFFF, 16'hFFFF);
    chk("mulu_max/const", {res_hi, res_lo}, 32'hFFFE_0001);
    run_op("divu1", 2'd1, 16'd100, 16'd7);
    chk("divu1/const", {res_hi, res_lo}, 32'h0002_000E);
    run_op("divu0", 2'd1, 16'h1234, 16'h0);
    chk("divu0/const", {res_hi, res_lo}, 32'h1234_FFFF);
    run_op("divu_big", 2'd1, 16'hFFFF, 16'h8001);
`ifdef ALU_SEQ_SIGNED_EN
    run_op("muls1", 2'd2, 16'hFFFA, 16'd7);
    chk("muls1/const", {res_hi, res_lo}, 32'hFFFF_FFD6);
    run_op("divs1", 2'd3, 16'hFFF9, 16'd2);
    chk("divs1/const", {res_hi, res_lo}, 32'hFFFF_FFFD);
    run_op("divs_min", 2'd3, 16'h8000, 16'hFFFF);
`endif

    // Handshake: start held high across an op
    e = model(2'd0, 16'h0003, 16'h0005);
    @(negedge clk);
    start = 1'b1; op = 2'd0; opnd_a = 16'h0003; opnd_b = 16'h0005;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("hs/lat", n, 19);
    chk("hs/busy_done", {31'b0, busy}, 32'd0);
    chk("hs/res", {res_hi, res_lo}, e[31:0]);
    @(negedge clk);
    chk("hs/idle_after_done", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("hs/reaccept", {31'b0, busy}, 32'd1);
    start = 1'b0;
    n = 1;
    while (n < 60 && !done) begin
      @(negedge clk);
      n++;
    end
    chk("hs/lat2", n, 19);
    chk("hs/res2", {res_hi, res_lo}, e[31:0]);

    // Reset during RUN cycle 8 aborts with no done pulse
    @(negedge clk);
    start = 1'b1; op = 2'd1; opnd_a = 16'hBEEF; opnd_b = 16'h0013;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort/busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort/busy", {31'b0, busy}, 32'd0);
    chk("abort/done", {31'b0, done}, 32'd0);
    chk("abort/res", {res_hi, res_lo}, 32'd0);
    chk("abort/alu_op", {29'b0, alu_op}, 32'd0);
    chk("abort/div0", {31'b0, div0}, 32'd0);
    @(negedge clk);
    chk("abort/done2", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    run_op("after_abort", 2'd0, 16'h1234, 16'h5678);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [15:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 16'h8000;
        1: ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: rb = 16'h0;
        1: rb = 16'hFFFF;
        2: rb = 16'h1;
        default: rb = 16'($urandom);
      endcase
      run_op("rand", ro, ra, rb);
    end

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that borrows the shared 16-bit combinational ALU to run 16x16 multiply and 16/16 divide.
- Sits beside the execute stage.
- While `busy`, it owns the ALU operand/op mux through `alu_own`.
- It reports results through a start/done handshake to the control unit.

Parameters:
- WIDTH, 16, operand width; must match the ALU width.
- CNT_W, 5, iteration counter width; ceil(log2(WIDTH))+1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- start  in  1  request; accepted only when `busy`=0.
- op  in  2  0=MULU, 1=DIVU, 2=MUL signed, 3=DIV signed.
- opnd_a  in  WIDTH  multiplicand / dividend; sampled at accept.
- opnd_b  in  WIDTH  multiplier / divisor; sampled at accept.
- busy  out  1  high from the cycle after accept until `done`.
- done  out  1  one-cycle pulse when results become valid.
- res_hi  out  WIDTH  product[31:16] / remainder.
- res_lo  out  WIDTH  product[15:0] / quotient.
- div0  out  1  divide-by-zero flag, valid with `done`.
- alu_own  out  1  equals `busy`; selects the sequencer onto the ALU inputs.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_op  out  3  ALU opcode: 2=add, 6=sub.
- alu_r  in  WIDTH  ALU result (combinational return).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; counter, hi, lo and all outputs are 0.
  - `alu_op`=0.
  - Reset aborts any operation with no `done` pulse.
- States: IDLE, PRE, RUN, POST, DONE.
- IDLE:
  - start=1 latches op, a and b, and moves to PRE.
  - start while `busy` is ignored; there is no queue.
- PRE (1 cycle):
  - Unsigned ops: take |a|, |b| as-is. Signed ops: negate locally.
  - Record the sign of the result.
  - DIV with b==0: go directly to DONE with res_lo=16'hFFFF, res_hi=a (raw), div0=1.
  - Otherwise clear hi, set lo=operand a (DIV) or operand b (MUL), counter=WIDTH, go to RUN.
- RUN (exactly 16 cycles, one iteration per cycle):
  - MUL iteration:
    - alu_a=hi, alu_b=multiplicand, alu_op=add.
    - carry = (alu_r < hi), computed locally.
    - If lo[0]: {carry,alu_r,lo} >> 1 into {hi,lo}; else {0,hi,lo} >> 1.
  - DIV iteration:
    - {msb,rsh} = {hi,lo[15]}.
    - alu_a=rsh, alu_b=divisor, alu_op=sub.
    - ge = msb | ~(rsh < divisor).
    - hi = ge ? alu_r : rsh.
    - lo = {lo[14:0], ge}.
  - Counter decrements each cycle; at 1, go to POST.
- POST (1 cycle):
  - Signed MUL with negative sign: negate the 32-bit {hi,lo}.
  - Signed DIV: quotient takes sign(a)^sign(b); remainder takes sign(a).
  - Unsigned ops pass through unchanged.
- DONE (1 cycle):
  - Drive res_hi/res_lo; `done`=1, `busy`=0; return to IDLE.
  - Results and div0 hold until the next accept.
  - start in the DONE cycle is ignored.
- Latency:
  - accept edge to `done`: 19 cycles (PRE + 16 RUN + POST + DONE).
  - Divide-by-zero: 2 cycles.
- Outside RUN: alu_a=0, alu_b=0, alu_op=0.

Optional Feature:
- Macro: ALU_SEQ_SIGNED_EN.
- Defined: ops 2/3 are signed, as above.
- Undefined: ops 2/3 alias ops 0/1, the PRE/POST negation logic is not built, and latency stays 19 cycles (PRE/POST become pass-through).

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SLT=4, ALU_SUB=6.
  - Sequencer op encodings SEQ_MULU..SEQ_DIVS.
  - State enum.
  - WIDTH default.
- One natural sub-module, alu_seq_negate: 32-bit two's-complement conditional negator, used in PRE and POST.

Test Plan:
- MULU a=0x1234, b=0x5678 -> after 19 cycles done=1, res_hi=0x0626, res_lo=0x0060; alu_op=2 for exactly 16 cycles.
- MULU a=0xFFFF, b=0xFFFF -> res_hi=0xFFFE, res_lo=0x0001 (carry path).
- DIVU a=100, b=7 -> res_lo=0x000E, res_hi=0x0002, div0=0; DIVU a=0x1234, b=0 -> done 2 cycles after accept, res_lo=0xFFFF, res_hi=0x1234, div0=1.
- With ALU_SEQ_SIGNED_EN: MUL a=0xFFFA, b=7 -> {res_hi,res_lo}=0xFFFF_FFD6; DIV a=0xFFF9, b=2 -> res_lo=0xFFFD, res_hi=0xFFFF.
- Handshake: start held high throughout an op -> second accept only in the cycle after `done`; `busy` stays low during the DONE cycle; `alu_own` equals `busy` every cycle.
- rst_n=0 at RUN cycle 8 -> next cycle busy=0, done=0, results=0, alu_op=0; a new start then completes normally.
